sign_monitor: RTL and testbench
===============================

SIGN_MONITOR -- requirements
Module: sign_monitor

Interface
REQ-001 Parameter RUN_W, default 8: run-length counter width in bits.
REQ-002 Parameter RUN_LIMIT, default 16: run length at which run_alarm_o asserts; legal range 1..2^RUN_W-1.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 valid_i  input  1  flags qualify a new sample this cycle.
REQ-006 positive_flag  input  1  upstream sign classifier: sample > 0.
REQ-007 negative_flag  input  1  upstream sign classifier: sample < 0.
REQ-008 clear_i  input  1  synchronous clear of all state, including fault.
REQ-009 state_o  output  2  current sign state: ZERO=0, POS=1, NEG=2, FAULT=3.
REQ-010 run_len_o  output  RUN_W  consecutive accepted samples in current state, saturating.
REQ-011 sign_change_o  output  1  one-cycle pulse on a direct POS<->NEG transition.
REQ-012 run_alarm_o  output  1  level; high while run_len_o >= RUN_LIMIT and state_o is POS or NEG.
REQ-013 fault_o  output  1  sticky; both input flags seen high on an accepted sample.
REQ-014 pos_count_o  output  16  total accepted positive samples, modulo 2^16.
REQ-015 neg_count_o  output  16  total accepted negative samples, modulo 2^16.

Function
REQ-016 Sample classification when valid_i=1: P = pos&~neg, N = neg&~pos, Z = neither flag, X = both flags.
REQ-017 All outputs are registered; an accepted sample at edge k is reflected on the outputs after edge k (latency 1).
REQ-018 valid_i=0: all state holds; sign_change_o=0.
REQ-019 FSM transitions on an accepted sample, from ZERO/POS/NEG: P->POS, N->NEG, Z->ZERO, X->FAULT.
REQ-020 FAULT is absorbing: accepted samples are ignored (no counter, run or pulse updates) until clear_i or reset.
REQ-021 On entering FAULT: fault_o=1, run_len_o=0, run_alarm_o=0.
REQ-022 Run length: class equal to the current state -> run_len_o+1, saturating at 2^RUN_W-1; different class -> run_len_o=1.
REQ-023 First accepted sample after reset or clear: run_len_o=1, including a Z sample while already in ZERO.
REQ-024 sign_change_o=1 for exactly the cycle after an accepted sample moves POS->NEG or NEG->POS; a ZERO between them produces no pulse.
REQ-025 pos_count_o / neg_count_o increment on each accepted P / N sample outside FAULT; they wrap 0xFFFF->0x0000.
REQ-026 clear_i has priority over valid_i in the same cycle: all state returns to reset values and the sample is discarded.
REQ-027 run_alarm_o is derived from registered state only; it never asserts in ZERO or FAULT.

Reset
REQ-028 rst_n=0 asynchronously forces state_o=ZERO, run_len_o=0, sign_change_o=0, run_alarm_o=0, fault_o=0, pos_count_o=0, neg_count_o=0.
REQ-029 Reset asserted mid-run discards all history; the first accepted sample after release behaves as in REQ-023.
REQ-030 rst_n deassertion is taken synchronously to clk; no sample is accepted on the release edge.

Verification
REQ-031 Use RUN_W=8, RUN_LIMIT=4 for the directed scenarios below.
REQ-032 Scenario 1, positive run: five P samples -> state_o=POS; run_len_o=1,2,3,4,5; run_alarm_o rises with run_len_o=4; pos_count_o=5.
REQ-033 Scenario 2, direct flip: P, P, N -> sign_change_o pulses once after the N; state_o=NEG; run_len_o=1; run_alarm_o=0.
REQ-034 Scenario 3, flip through zero: P, Z, N -> no sign_change_o pulse; state_o sequence POS, ZERO, NEG.
REQ-035 Scenario 4, exclusivity fault: P, then X, then three P -> fault_o=1 and state_o=FAULT persist; pos_count_o stays 1; clear_i -> all outputs at reset values.
REQ-036 Scenario 5, saturation and wrap:
  - 300 N samples -> run_len_o holds at 255.
  - Preload via 65536 P samples -> pos_count_o=0.
REQ-037 Scenario 6, priority and reset:
  - clear_i and valid_i with P in the same cycle -> counters stay 0.
  - rst_n pulsed low mid-run -> outputs clear immediately, with no clk edge required.

Source files
------------

// File: rtl/sign_monitor.sv
// Sign-state monitor: tracks the sign of a qualified sample stream, its run
// length, direct sign flips, per-sign sample counts and a sticky exclusivity fault.
module sign_monitor #(
    parameter int RUN_W     = 8,
    parameter int RUN_LIMIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             positive_flag,
    input  logic             negative_flag,
    input  logic             clear_i,
    output logic [1:0]       state_o,
    output logic [RUN_W-1:0] run_len_o,
    output logic             sign_change_o,
    output logic             run_alarm_o,
    output logic             fault_o,
    output logic [15:0]      pos_count_o,
    output logic [15:0]      neg_count_o
);

    localparam logic [1:0]       ST_ZERO  = 2'd0;
    localparam logic [1:0]       ST_POS   = 2'd1;
    localparam logic [1:0]       ST_NEG   = 2'd2;
    localparam logic [1:0]       ST_FAULT = 2'd3;
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_THR  = RUN_W'(RUN_LIMIT);

    logic [1:0]       state_q, state_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic             sign_change_q, sign_change_d;
    logic             fault_q, fault_d;
    logic [15:0]      pos_cnt_q, pos_cnt_d;
    logic [15:0]      neg_cnt_q, neg_cnt_d;
    logic             ready_q, ready_d;

    logic [1:0] cls;
    logic       accept;

    // Flag pair maps straight onto the state encoding: {neg,pos} = 01 POS, 10 NEG, 00 ZERO, 11 FAULT.
    assign cls    = {negative_flag, positive_flag};
    // ready_q holds samples off on the edge that releases reset.
    assign accept = valid_i && ready_q && (state_q != ST_FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ZERO;
            run_len_q     <= '0;
            sign_change_q <= 1'b0;
            fault_q       <= 1'b0;
            pos_cnt_q     <= '0;
            neg_cnt_q     <= '0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_len_q     <= run_len_d;
            sign_change_q <= sign_change_d;
            fault_q       <= fault_d;
            pos_cnt_q     <= pos_cnt_d;
            neg_cnt_q     <= neg_cnt_d;
            ready_q       <= ready_d;
        end
    end

    // Next-state logic: a fresh run starts from 0, so the first sample after
    // reset or clear lands on run length 1 even when the class matches ZERO.
    always_comb begin
        state_d       = state_q;
        run_len_d     = run_len_q;
        sign_change_d = 1'b0;
        fault_d       = fault_q;
        pos_cnt_d     = pos_cnt_q;
        neg_cnt_d     = neg_cnt_q;
        ready_d       = 1'b1;

        if (clear_i) begin
            state_d   = ST_ZERO;
            run_len_d = '0;
            fault_d   = 1'b0;
            pos_cnt_d = '0;
            neg_cnt_d = '0;
        end else if (accept) begin
            if (cls == ST_FAULT) begin
                state_d   = ST_FAULT;
                fault_d   = 1'b1;
                run_len_d = '0;
            end else begin
                state_d       = cls;
                sign_change_d = ((state_q == ST_POS) && (cls == ST_NEG)) ||
                                ((state_q == ST_NEG) && (cls == ST_POS));
                if (cls == state_q) begin
                    run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + 1'b1;
                end else begin
                    run_len_d = RUN_W'(1);
                end
                if (cls == ST_POS) pos_cnt_d = pos_cnt_q + 16'd1;
                if (cls == ST_NEG) neg_cnt_d = neg_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        state_o       = state_q;
        run_len_o     = run_len_q;
        sign_change_o = sign_change_q;
        fault_o       = fault_q;
        pos_count_o   = pos_cnt_q;
        neg_count_o   = neg_cnt_q;
        run_alarm_o   = ((state_q == ST_POS) || (state_q == ST_NEG)) && (run_len_q >= RUN_THR);
    end

endmodule

// File: tb/tb_sign_monitor.sv
// Bench for sign_monitor: directed scenarios plus randomized traffic against
// a behavioural model of the sign-run rules.
module tb_sign_monitor;

    localparam int RUN_W     = 8;
    localparam int RUN_LIMIT = 4;
    localparam int RUN_SAT   = 255;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid_i = 1'b0;
    logic             positive_flag = 1'b0;
    logic             negative_flag = 1'b0;
    logic             clear_i = 1'b0;
    logic [1:0]       state_o;
    logic [RUN_W-1:0] run_len_o;
    logic             sign_change_o;
    logic             run_alarm_o;
    logic             fault_o;
    logic [15:0]      pos_count_o;
    logic [15:0]      neg_count_o;

    int total = 0;
    int bad   = 0;

    // Reference model state (plain integers).
    int  m_state, m_run, m_pos, m_neg;
    bit  m_chg, m_fault, m_ready;

    sign_monitor #(.RUN_W(RUN_W), .RUN_LIMIT(RUN_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i),
        .positive_flag(positive_flag), .negative_flag(negative_flag),
        .clear_i(clear_i), .state_o(state_o), .run_len_o(run_len_o),
        .sign_change_o(sign_change_o), .run_alarm_o(run_alarm_o),
        .fault_o(fault_o), .pos_count_o(pos_count_o), .neg_count_o(neg_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_pos = 0; m_neg = 0; m_chg = 0; m_fault = 0;
    endtask

    task automatic model_edge(input bit v, input bit p, input bit n, input bit c);
        int cls;
        m_chg = 0;
        if (c) begin
            model_reset();
        end else if (m_ready && v && m_state != 3) begin
            if (p && n)       cls = 3;
            else if (p)       cls = 1;
            else if (n)       cls = 2;
            else              cls = 0;
            if (cls == 3) begin
                m_state = 3; m_fault = 1; m_run = 0;
            end else begin
                m_chg = (m_state == 1 && cls == 2) || (m_state == 2 && cls == 1);
                m_run = (cls == m_state) ? ((m_run + 1 > RUN_SAT) ? RUN_SAT : m_run + 1) : 1;
                m_state = cls;
                if (cls == 1) m_pos = (m_pos + 1) % 65536;
                if (cls == 2) m_neg = (m_neg + 1) % 65536;
            end
        end
        m_ready = 1;
    endtask

    task automatic check_all();
        chk("state", int'(state_o), m_state);
        chk("run_len", int'(run_len_o), m_run);
        chk("sign_change", int'(sign_change_o), int'(m_chg));
        chk("run_alarm", int'(run_alarm_o),
            int'((m_state == 1 || m_state == 2) && m_run >= RUN_LIMIT));
        chk("fault", int'(fault_o), int'(m_fault));
        chk("pos_count", int'(pos_count_o), m_pos);
        chk("neg_count", int'(neg_count_o), m_neg);
    endtask

    task automatic step(input bit v, input bit p, input bit n, input bit c);
        @(negedge clk);
        valid_i = v; positive_flag = p; negative_flag = n; clear_i = c;
        @(posedge clk);
        model_edge(v, p, n, c);
        #1;
        check_all();
    endtask

    // Releases reset while offering a P sample; that edge must not take it.
    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b1; positive_flag = 1'b1; negative_flag = 1'b0; clear_i = 1'b0;
        @(posedge clk);
        #1;
        chk("release_state", int'(state_o), 0);
        chk("release_run", int'(run_len_o), 0);
        chk("release_pos", int'(pos_count_o), 0);
        m_ready = 1;
    endtask

    task automatic check_zeroed(input string tag);
        chk({tag, "_state"}, int'(state_o), 0);
        chk({tag, "_run"}, int'(run_len_o), 0);
        chk({tag, "_chg"}, int'(sign_change_o), 0);
        chk({tag, "_alarm"}, int'(run_alarm_o), 0);
        chk({tag, "_fault"}, int'(fault_o), 0);
        chk({tag, "_pos"}, int'(pos_count_o), 0);
        chk({tag, "_neg"}, int'(neg_count_o), 0);
    endtask

    initial begin
        int cls;
        model_reset();
        m_ready = 0;
        #2;
        check_zeroed("reset");
        repeat (3) @(posedge clk);
        release_reset();

        // Scenario 1: positive run
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0);
            chk("s1_run", int'(run_len_o), i + 1);
            chk("s1_alarm", int'(run_alarm_o), int'(i + 1 >= 4));
        end
        chk("s1_state", int'(state_o), 1);
        chk("s1_pos", int'(pos_count_o), 5);

        // Scenario 2: direct flip
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("s2_nochg", int'(sign_change_o), 0);
        step(1, 0, 1, 0);
        chk("s2_chg", int'(sign_change_o), 1);
        chk("s2_state", int'(state_o), 2);
        chk("s2_run", int'(run_len_o), 1);
        chk("s2_alarm", int'(run_alarm_o), 0);
        step(0, 0, 0, 0);
        chk("s2_chg_once", int'(sign_change_o), 0);

        // Scenario 3: flip through zero
        step(0, 0, 0, 1);
        step(1, 1, 0, 0); chk("s3_pos", int'(state_o), 1); chk("s3_c0", int'(sign_change_o), 0);
        step(1, 0, 0, 0); chk("s3_zero", int'(state_o), 0); chk("s3_c1", int'(sign_change_o), 0);
        step(1, 0, 1, 0); chk("s3_neg", int'(state_o), 2); chk("s3_c2", int'(sign_change_o), 0);

        // Scenario 4: exclusivity fault
        step(0, 0, 0, 1);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
        chk("s4_fault", int'(fault_o), 1);
        chk("s4_state", int'(state_o), 3);
        chk("s4_pos", int'(pos_count_o), 1);
        chk("s4_run", int'(run_len_o), 0);
        step(0, 0, 0, 1);
        check_zeroed("s4_clear");

        // Scenario 5: saturation and wrap
        for (int i = 0; i < 300; i++) step(1, 0, 1, 0);
        chk("s5_sat", int'(run_len_o), 255);
        chk("s5_neg", int'(neg_count_o), 300);
        for (int i = 0; i < 65536; i++) step(1, 1, 0, 0);
        chk("s5_wrap", int'(pos_count_o), 0);
        chk("s5_sat_pos", int'(run_len_o), 255);

        // Scenario 6: clear priority, then async reset mid-run
        step(1, 1, 0, 1);
        check_zeroed("s6_clrprio");
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zeroed("s6_async");
        model_reset();
        m_ready = 0;
        repeat (2) @(posedge clk);
        release_reset();
        step(1, 0, 0, 0);
        chk("s6_first_z_run", int'(run_len_o), 1);

        // Randomized traffic with sticky classes so runs grow long
        cls = 1;
        for (int i = 0; i < 4000; i++) begin
            bit v, c;
            if ($urandom_range(0, 3) == 0) begin
                cls = ($urandom_range(0, 40) == 0) ? 3 : int'($urandom_range(0, 2));
            end
            v = ($urandom_range(0, 9) < 8);
            c = ($urandom_range(0, 59) == 0);
            step(v, (cls == 1) || (cls == 3), (cls == 2) || (cls == 3), c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
